// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl
// Purpose  : Button debounce and RUN/time-set/alarm-set sequencing for the
//            24 h clock; optional hold-to-repeat via CLOCK_MODE_CTRL_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clock_mode_ctrl #(
  parameter int DEBOUNCE_MS   = 20,
  parameter int TIMEOUT_MS    = 30000,
  parameter int BLINK_MS      = 250,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick_1ms,
  input  logic       btn_mode,
  input  logic       btn_adj,
  output logic [2:0] mode,
  output logic       clk_hour_inc,
  output logic       clk_min_inc,
  output logic       alm_hour_inc,
  output logic       alm_min_inc,
  output logic       sec_hold,
  output logic       sec_clr,
  output logic       disp_alarm,
  output logic       blink,
  output logic       alarm_armed
);

  localparam int c_MAX_1 = (DEBOUNCE_MS > TIMEOUT_MS) ? DEBOUNCE_MS : TIMEOUT_MS;
  localparam int c_MAX_2 = (c_MAX_1 > BLINK_MS) ? c_MAX_1 : BLINK_MS;
  localparam int c_MAX_3 = (c_MAX_2 > LONG_PRESS_MS) ? c_MAX_2 : LONG_PRESS_MS;
  localparam int c_MAX   = (c_MAX_3 > REPEAT_MS) ? c_MAX_3 : REPEAT_MS;
  localparam int c_CW    = $clog2(c_MAX + 1);

  localparam logic [c_CW-1:0] c_ONE        = c_CW'(1);
  localparam logic [c_CW-1:0] c_DEB        = c_CW'(DEBOUNCE_MS);
  localparam logic [c_CW-1:0] c_TO         = c_CW'(TIMEOUT_MS);
  localparam logic [c_CW-1:0] c_BLINK_LAST = c_CW'(BLINK_MS - 1);

  localparam int c_BTN_MODE = 0;
  localparam int c_BTN_ADJ  = 1;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_ALM_HOUR = 3'd3,
    ST_ALM_MIN  = 3'd4
  } state_t;

  logic [1:0]      w_raw;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_deb;
  logic [1:0]      r_deb_d;
  logic [1:0]      r_qual;
  logic [c_CW-1:0] r_deb_cnt [2];
  logic [1:0]      w_press;

  state_t          r_state;
  state_t          w_next;
  logic            w_timeout;
  logic            w_mode_ev;
  logic            w_adj_ev;
  logic            w_inc_ev;
  logic            w_rep_fire;
  logic [c_CW-1:0] r_to_cnt;
  logic [c_CW-1:0] r_blink_cnt;
  logic            r_blink_ph;
  logic [c_CW-1:0] w_blink_cnt_n;
  logic            w_blink_ph_n;

  logic r_clk_hour_inc;
  logic r_clk_min_inc;
  logic r_alm_hour_inc;
  logic r_alm_min_inc;
  logic r_sec_hold;
  logic r_sec_clr;
  logic r_disp_alarm;
  logic r_blink;
  logic r_alarm_armed;

  assign w_raw = {btn_adj, btn_mode};

  // r_qual blocks a press from a button that was already held through reset
  // until the synchronized level has been seen low on a tick.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_qual  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (tick_1ms) begin
        r_qual <= r_qual | ~r_sync2;
        for (int i = 0; i < 2; i++) begin
          if (r_sync2[i] != r_deb[i]) begin
            if ((r_deb_cnt[i] + c_ONE) == c_DEB) begin
              r_deb[i]     <= r_sync2[i];
              r_deb_cnt[i] <= '0;
            end else begin
              r_deb_cnt[i] <= r_deb_cnt[i] + c_ONE;
            end
          end else begin
            r_deb_cnt[i] <= '0;
          end
        end
      end
    end
  end

  assign w_press = r_deb & ~r_deb_d & r_qual;

  always_comb begin
    w_timeout = (r_state != ST_RUN) && (r_to_cnt == c_TO);
    w_mode_ev = w_press[c_BTN_MODE] && !w_timeout;
    w_adj_ev  = w_press[c_BTN_ADJ] && !w_press[c_BTN_MODE] && !w_timeout;
    w_next    = r_state;
    if (w_timeout) begin
      w_next = ST_RUN;
    end else if (w_mode_ev) begin
      case (r_state)
        ST_RUN:      w_next = ST_SET_HOUR;
        ST_SET_HOUR: w_next = ST_SET_MIN;
        ST_SET_MIN:  w_next = ST_ALM_HOUR;
        ST_ALM_HOUR: w_next = ST_ALM_MIN;
        ST_ALM_MIN:  w_next = ST_RUN;
        default:     w_next = ST_RUN;
      endcase
    end
  end

  assign w_inc_ev = w_adj_ev || w_rep_fire;

  always_comb begin
    w_blink_cnt_n = r_blink_cnt;
    w_blink_ph_n  = r_blink_ph;
    if (w_next == ST_RUN) begin
      w_blink_cnt_n = '0;
      w_blink_ph_n  = 1'b0;
    end else if (w_next != r_state) begin
      w_blink_cnt_n = '0;
      w_blink_ph_n  = 1'b1;
    end else if (tick_1ms) begin
      if (r_blink_cnt == c_BLINK_LAST) begin
        w_blink_cnt_n = '0;
        w_blink_ph_n  = ~r_blink_ph;
      end else begin
        w_blink_cnt_n = r_blink_cnt + c_ONE;
      end
    end
  end

`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
  localparam logic [c_CW-1:0] c_LONG = c_CW'(LONG_PRESS_MS);
  localparam logic [c_CW-1:0] c_REP  = c_CW'(REPEAT_MS);

  logic            r_rep_act;
  logic            r_rep_long;
  logic [c_CW-1:0] r_rep_cnt;
  logic [c_CW-1:0] w_rep_cnt_inc;

  assign w_rep_cnt_inc = r_rep_cnt + c_ONE;
  assign w_rep_fire    = r_rep_act && tick_1ms && r_deb[c_BTN_ADJ] &&
                         !w_press[c_BTN_MODE] && !w_timeout &&
                         (w_rep_cnt_inc == (r_rep_long ? c_REP : c_LONG));

  // Hold timer counts ticks since the adj press; first interval is the
  // long-press delay, then the repeat interval.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rep_act  <= 1'b0;
      r_rep_long <= 1'b0;
      r_rep_cnt  <= '0;
    end else if (w_adj_ev && (r_state != ST_RUN)) begin
      r_rep_act  <= 1'b1;
      r_rep_long <= 1'b0;
      r_rep_cnt  <= '0;
    end else if (!r_deb[c_BTN_ADJ] || w_press[c_BTN_MODE] || w_timeout ||
                 (w_next != r_state)) begin
      r_rep_act <= 1'b0;
    end else if (r_rep_act && tick_1ms) begin
      if (w_rep_fire) begin
        r_rep_cnt  <= '0;
        r_rep_long <= 1'b1;
      end else begin
        r_rep_cnt <= w_rep_cnt_inc;
      end
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state        <= ST_RUN;
      r_clk_hour_inc <= 1'b0;
      r_clk_min_inc  <= 1'b0;
      r_alm_hour_inc <= 1'b0;
      r_alm_min_inc  <= 1'b0;
      r_sec_hold     <= 1'b0;
      r_sec_clr      <= 1'b0;
      r_disp_alarm   <= 1'b0;
      r_blink        <= 1'b0;
      r_alarm_armed  <= 1'b0;
      r_to_cnt       <= '0;
      r_blink_cnt    <= '0;
      r_blink_ph     <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_clk_hour_inc <= w_inc_ev && (r_state == ST_SET_HOUR);
      r_clk_min_inc  <= w_inc_ev && (r_state == ST_SET_MIN);
      r_alm_hour_inc <= w_inc_ev && (r_state == ST_ALM_HOUR);
      r_alm_min_inc  <= w_inc_ev && (r_state == ST_ALM_MIN);
      // Leaving SET_MIN by either mode press or timeout zeroes the seconds.
      r_sec_clr      <= (r_state == ST_SET_MIN) && (w_next != ST_SET_MIN);
      r_sec_hold     <= (w_next == ST_SET_HOUR) || (w_next == ST_SET_MIN);
      r_disp_alarm   <= (w_next == ST_ALM_HOUR) || (w_next == ST_ALM_MIN);
      if (w_adj_ev && (r_state == ST_RUN)) begin
        r_alarm_armed <= ~r_alarm_armed;
      end
      if ((w_next == ST_RUN) || (w_next != r_state) || (w_press != 2'b00) || w_rep_fire) begin
        r_to_cnt <= '0;
      end else if (tick_1ms && (r_to_cnt != c_TO)) begin
        r_to_cnt <= r_to_cnt + c_ONE;
      end
      r_blink_cnt <= w_blink_cnt_n;
      r_blink_ph  <= w_blink_ph_n;
      r_blink     <= (w_next != ST_RUN) && (w_blink_ph_n || r_deb[c_BTN_ADJ]);
    end
  end

  assign mode         = r_state;
  assign clk_hour_inc = r_clk_hour_inc;
  assign clk_min_inc  = r_clk_min_inc;
  assign alm_hour_inc = r_alm_hour_inc;
  assign alm_min_inc  = r_alm_min_inc;
  assign sec_hold     = r_sec_hold;
  assign sec_clr      = r_sec_clr;
  assign disp_alarm   = r_disp_alarm;
  assign blink        = r_blink;
  assign alarm_armed  = r_alarm_armed;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_mode_ctrl
// Purpose  : Self-checking bench for clock_mode_ctrl against a mode/press model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_mode_ctrl;

  localparam int DEB = 2;
  localparam int TO  = 50;
  localparam int BL  = 5;
  localparam int LP  = 10;
  localparam int RP  = 4;

  logic       clk;
  logic       clr;
  logic       tick_1ms;
  logic       btn_mode;
  logic       btn_adj;
  logic [2:0] mode;
  logic       clk_hour_inc;
  logic       clk_min_inc;
  logic       alm_hour_inc;
  logic       alm_min_inc;
  logic       sec_hold;
  logic       sec_clr;
  logic       disp_alarm;
  logic       blink;
  logic       alarm_armed;

  clock_mode_ctrl #(
    .DEBOUNCE_MS   (DEB),
    .TIMEOUT_MS    (TO),
    .BLINK_MS      (BL),
    .LONG_PRESS_MS (LP),
    .REPEAT_MS     (RP)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .tick_1ms     (tick_1ms),
    .btn_mode     (btn_mode),
    .btn_adj      (btn_adj),
    .mode         (mode),
    .clk_hour_inc (clk_hour_inc),
    .clk_min_inc  (clk_min_inc),
    .alm_hour_inc (alm_hour_inc),
    .alm_min_inc  (alm_min_inc),
    .sec_hold     (sec_hold),
    .sec_clr      (sec_clr),
    .disp_alarm   (disp_alarm),
    .blink        (blink),
    .alarm_armed  (alarm_armed)
  );

  int checks   = 0;
  int failures = 0;

  // observed pulse counts
  int n_ch = 0, n_cm = 0, n_ah = 0, n_am = 0, n_sc = 0, n_bad = 0;
  int tick_cnt = 0;
  int ch_ticks[$];

  // reference model
  int exp_mode  = 0;
  int exp_armed = 0;
  int e_ch = 0, e_cm = 0, e_ah = 0, e_am = 0, e_sc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick_1ms = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick_1ms = 1'b1;
      @(negedge clk);
      tick_1ms = 1'b0;
    end
  end

  always @(posedge clk) if (tick_1ms) tick_cnt++;

  always @(negedge clk) begin
    if (clk_hour_inc) begin
      n_ch++;
      ch_ticks.push_back(tick_cnt);
    end
    if (clk_min_inc)  n_cm++;
    if (alm_hour_inc) n_ah++;
    if (alm_min_inc)  n_am++;
    if (sec_clr)      n_sc++;
    if ($countones({clk_hour_inc, clk_min_inc, alm_hour_inc, alm_min_inc}) > 1) n_bad++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick_1ms !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic press(input bit is_mode, input bit is_adj, input int hold, input int gap);
    wait_ticks(1);
    if (is_mode) btn_mode = 1'b1;
    if (is_adj)  btn_adj  = 1'b1;
    wait_ticks(hold);
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    wait_ticks(gap);
  endtask

  function automatic void apply_mode();
    if (exp_mode == 2) e_sc++;
    exp_mode = (exp_mode + 1) % 5;
  endfunction

  function automatic void apply_adj();
    case (exp_mode)
      0: exp_armed = 1 - exp_armed;
      1: e_ch++;
      2: e_cm++;
      3: e_ah++;
      default: e_am++;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".mode"},       32'(mode), 32'(exp_mode));
    check({tag, ".armed"},      32'(alarm_armed), 32'(exp_armed));
    check({tag, ".sec_hold"},   32'(sec_hold), 32'(exp_mode == 1 || exp_mode == 2));
    check({tag, ".disp_alarm"}, 32'(disp_alarm), 32'(exp_mode == 3 || exp_mode == 4));
    check({tag, ".n_clk_hour"}, 32'(n_ch), 32'(e_ch));
    check({tag, ".n_clk_min"},  32'(n_cm), 32'(e_cm));
    check({tag, ".n_alm_hour"}, 32'(n_ah), 32'(e_ah));
    check({tag, ".n_alm_min"},  32'(n_am), 32'(e_am));
    check({tag, ".n_sec_clr"},  32'(n_sc), 32'(e_sc));
    if (exp_mode == 0) check({tag, ".blink_run"}, 32'(blink), 32'd0);
  endtask

  task automatic mode_press_rand();
    press(1'b1, 1'b0, $urandom_range(5, 3), $urandom_range(6, 3));
    apply_mode();
  endtask

  task automatic adj_press_rand();
    press(1'b0, 1'b1, $urandom_range(5, 3), $urandom_range(6, 3));
    apply_adj();
  endtask

  initial begin
    int base;
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    clr      = 1'b1;

    // 1. reset and debounce
    repeat (4) @(posedge clk);
    #1;
    check("rst.mode",       32'(mode), 32'd0);
    check("rst.blink",      32'(blink), 32'd0);
    check("rst.armed",      32'(alarm_armed), 32'd0);
    check("rst.sec_hold",   32'(sec_hold), 32'd0);
    check("rst.disp_alarm", 32'(disp_alarm), 32'd0);
    check("rst.pulses",     32'({clk_hour_inc, clk_min_inc, alm_hour_inc, alm_min_inc, sec_clr}), 32'd0);
    clr = 1'b0;
    wait_ticks(2);

    wait_ticks(1);
    btn_mode = 1'b1;
    wait_ticks(1);
    btn_mode = 1'b0;
    wait_ticks(4);
    check("glitch.mode", 32'(mode), 32'd0);

    wait_ticks(1);
    btn_mode = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("deb.mode_before", 32'(mode), 32'd0);
    @(posedge clk);
    #1;
    check("deb.mode_after", 32'(mode), 32'd1);
    check("deb.sec_hold",   32'(sec_hold), 32'd1);
    check("deb.blink",      32'(blink), 32'd1);
    exp_mode = 1;
    wait_ticks(1);
    btn_mode = 1'b0;
    check("blink.t1", 32'(blink), 32'd1);
    wait_ticks(5);
    check("blink.t6", 32'(blink), 32'd0);
    wait_ticks(5);
    check("blink.t11", 32'(blink), 32'd1);
    check_state("t1");

    // 2. mode cycle
    for (int i = 0; i < 9; i++) begin
      mode_press_rand();
      check_state("cycle");
    end

    // 3. increments in SET_MIN, then alarm arm in RUN
    mode_press_rand();
    mode_press_rand();
    check("inc.mode", 32'(mode), 32'd2);
    adj_press_rand();
    adj_press_rand();
    wait_ticks(1);
    btn_adj = 1'b1;
    wait_ticks(4);
    check("inc.blink_forced", 32'(blink), 32'd1);
    btn_adj = 1'b0;
    wait_ticks(3);
    apply_adj();
    check_state("inc");
    for (int i = 0; i < 3; i++) mode_press_rand();
    adj_press_rand();
    check_state("arm");

    // 4. simultaneous press, then timeout out of SET_MIN
    mode_press_rand();
    press(1'b1, 1'b1, 3, 3);
    apply_mode();
    check_state("simul");
    wait_ticks(40);
    check("timeout.before", 32'(mode), 32'd2);
    wait_ticks(15);
    exp_mode = 0;
    e_sc++;
    check_state("timeout");

    // 5. reset while adj held in ALM_MIN
    for (int i = 0; i < 4; i++) mode_press_rand();
    wait_ticks(1);
    btn_adj = 1'b1;
    wait_ticks(3);
    apply_adj();
    check("rmid.n_alm_min", 32'(n_am), 32'(e_am));
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_mode  = 0;
    exp_armed = 0;
    check("rmid.mode",   32'(mode), 32'd0);
    check("rmid.blink",  32'(blink), 32'd0);
    check("rmid.armed",  32'(alarm_armed), 32'd0);
    check("rmid.outs",   32'({clk_hour_inc, clk_min_inc, alm_hour_inc, alm_min_inc,
                              sec_clr, sec_hold, disp_alarm}), 32'd0);
    wait_ticks(6);
    check_state("rmid.held");
    btn_adj = 1'b0;
    wait_ticks(3);
    adj_press_rand();
    check_state("rmid.repress");

    // 6. randomized press sequence
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1) mode_press_rand();
      else adj_press_rand();
      check_state("rand");
    end

    // 7. long hold of adj in SET_HOUR
    while (exp_mode != 1) mode_press_rand();
    base = ch_ticks.size();
    wait_ticks(1);
    btn_adj = 1'b1;
    wait_ticks(25);
    btn_adj = 1'b0;
    wait_ticks(3);
`ifdef CLOCK_MODE_CTRL_AUTOREPEAT_EN
    e_ch += 5;
    check("rep.count", 32'(ch_ticks.size() - base), 32'd5);
    if (ch_ticks.size() - base == 5) begin
      check("rep.first",  32'(ch_ticks[base + 1] - ch_ticks[base]), 32'(LP));
      check("rep.second", 32'(ch_ticks[base + 2] - ch_ticks[base]), 32'(LP + RP));
      check("rep.third",  32'(ch_ticks[base + 3] - ch_ticks[base]), 32'(LP + 2 * RP));
      check("rep.fourth", 32'(ch_ticks[base + 4] - ch_ticks[base]), 32'(LP + 3 * RP));
    end
`else
    e_ch += 1;
    check("hold.count", 32'(ch_ticks.size() - base), 32'd1);
`endif
    check_state("hold");

    check("onehot.violations", 32'(n_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
